// File: rtl/cardio_feature_sequencer.sv
// cardio_feature_sequencer
// Serial front end for the combinational cardio SVM classifier. Collects the
// 21 four-bit features of one record from a valid/ready stream and packs them
// into clf_inp. It holds clf_inp stable for one evaluation cycle, then
// registers the classifier result and offers it downstream on valid/ready.
//
// Build option: define CARDIO_SEQ_FRAME_CHECK_EN to enable s_last framing
// checks. When enabled, a record whose s_last does not coincide with the 21st
// feature is discarded and frame_err pulses for one cycle. Without it, s_last
// is ignored and a record ends on its 21st feature.
module cardio_feature_sequencer #(
  parameter int NUM_FEAT = 21,
  parameter int FEAT_W   = 4,
  parameter int CLS_W    = 2,
  parameter int VOTE_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [FEAT_W-1:0]          s_data,
  input  logic                       s_last,
  output logic [NUM_FEAT*FEAT_W-1:0] clf_inp,
  input  logic [CLS_W-1:0]           clf_out,
  input  logic [VOTE_W-1:0]          clf_predo,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [CLS_W-1:0]           m_class,
  output logic [VOTE_W-1:0]          m_votes,
  output logic                       frame_err
);

  localparam int K_W = $clog2(NUM_FEAT);
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_FEAT - 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [K_W-1:0] k, k_nxt;
  logic           frame_err_nxt;
  logic           at_last;

  assign at_last = (k == K_LAST);

  // State and feature counter registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order of statements or blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // Next-state, counter and handshake decode.
  // NOTE: every variable gets a default at the top so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    k_nxt         = k;
    frame_err_nxt = 1'b0;
    s_ready       = 1'b0;
    m_valid       = 1'b0;
    case (state)
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
`ifdef CARDIO_SEQ_FRAME_CHECK_EN
          if (at_last && s_last) begin
            state_nxt = EVAL;
            k_nxt     = '0;
          end else if (at_last || s_last) begin
            // Misframed record: drop it and restart collection at slot 0.
            frame_err_nxt = 1'b1;
            k_nxt         = '0;
          end else begin
            k_nxt = k + 1'b1;
          end
`else
          if (at_last) begin
            state_nxt = EVAL;
            k_nxt     = '0;
          end else begin
            k_nxt = k + 1'b1;
          end
`endif
        end
      end
      EVAL: state_nxt = HOLD;
      HOLD: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Feature packing: each accepted word lands in slot k. Slots are simply
  // overwritten by the next record and never cleared in between.
  // NOTE: this wide register is reset because clf_inp feeds the classifier
  // directly and must read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clf_inp <= '0;
    end else if (state == FILL && s_valid) begin
      clf_inp[FEAT_W*k +: FEAT_W] <= s_data;
    end
  end

  // Capture the classifier result at the end of the single EVAL cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_class <= '0;
      m_votes <= '0;
    end else if (state == EVAL) begin
      m_class <= clf_out;
      m_votes <= clf_predo;
    end
  end

`ifdef CARDIO_SEQ_FRAME_CHECK_EN
  // One-cycle framing error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= frame_err_nxt;
  end
`else
  logic unused_frame;
  assign unused_frame = s_last | frame_err_nxt;
  assign frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cardio_feature_sequencer.sv
// Self-checking bench for cardio_feature_sequencer. A small stand-in
// classifier sits on clf_inp: class = feature20[3:2],
// votes = {feature20[1:0], feature0} ^ 6'h21 (all-zero record -> class 0,
// votes 6'h21). Expected results in the vector table are hand-computed.
module tb_cardio_feature_sequencer;

  localparam int NUM_FEAT = 21;
  localparam int FEAT_W   = 4;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_data;
  logic        s_last;
  logic [83:0] clf_inp;
  logic [1:0]  clf_out;
  logic [5:0]  clf_predo;
  logic        m_valid;
  logic        m_ready;
  logic [1:0]  m_class;
  logic [5:0]  m_votes;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;

  cardio_feature_sequencer #(
    .NUM_FEAT(NUM_FEAT), .FEAT_W(FEAT_W), .CLS_W(2), .VOTE_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .clf_inp(clf_inp), .clf_out(clf_out), .clf_predo(clf_predo),
    .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_votes(m_votes),
    .frame_err(frame_err)
  );

  // Stand-in combinational classifier.
  always_comb begin
    clf_out   = clf_inp[83:82];
    clf_predo = {clf_inp[81:80], clf_inp[3:0]} ^ 6'h21;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         base;
    int         step;
    int         bp;
    logic [1:0] cls;
    logic [5:0] votes;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] feat(input int base, input int step, input int k);
    return 4'((base + step * k) & 15);
  endfunction

  // Present one feature, let one clock edge pass, sample point is edge+1.
  task automatic drive_feat(input logic [3:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Full record: fill, EVAL checks, HOLD checks with bp backpressure cycles.
  task automatic run_record(input int base, input int step, input int bp,
                            input logic [1:0] ecls, input logic [5:0] evotes);
    logic [83:0] exp_inp;
    exp_inp = '0;
    m_ready = (bp == 0);
    for (int k = 0; k < NUM_FEAT; k++) begin
      exp_inp[4*k +: 4] = feat(base, step, k);
      drive_feat(feat(base, step, k), k == NUM_FEAT - 1);
    end
    check("eval_s_ready", 96'(s_ready), 96'(0));
    check("eval_m_valid", 96'(m_valid), 96'(0));
    check("eval_clf_inp", 96'(clf_inp), 96'(exp_inp));
    @(posedge clk);
    #1;
    check("hold_m_valid", 96'(m_valid), 96'(1));
    check("hold_s_ready", 96'(s_ready), 96'(0));
    check("hold_m_class", 96'(m_class), 96'(ecls));
    check("hold_m_votes", 96'(m_votes), 96'(evotes));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      check("bp_m_valid", 96'(m_valid), 96'(1));
      check("bp_s_ready", 96'(s_ready), 96'(0));
      check("bp_m_class", 96'(m_class), 96'(ecls));
      check("bp_m_votes", 96'(m_votes), 96'(evotes));
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_m_valid", 96'(m_valid), 96'(0));
    check("release_s_ready", 96'(s_ready), 96'(1));
  endtask

  initial begin : main
    int hits[$];
    int idx;
    logic rdy;

    tbl[0] = '{base: 0,  step: 0, bp: 0, cls: 2'd0, votes: 6'h21};
    tbl[1] = '{base: 0,  step: 1, bp: 0, cls: 2'd1, votes: 6'h21};
    tbl[2] = '{base: 15, step: 0, bp: 5, cls: 2'd3, votes: 6'h1E};
    tbl[3] = '{base: 3,  step: 5, bp: 2, cls: 2'd1, votes: 6'h12};
    tbl[4] = '{base: 10, step: 3, bp: 0, cls: 2'd1, votes: 6'h0B};
    tbl[5] = '{base: 8,  step: 7, bp: 1, cls: 2'd1, votes: 6'h29};

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;

    // Reset state.
    #12;
    check("rst_s_ready",   96'(s_ready),   96'(1));
    check("rst_m_valid",   96'(m_valid),   96'(0));
    check("rst_m_class",   96'(m_class),   96'(0));
    check("rst_m_votes",   96'(m_votes),   96'(0));
    check("rst_clf_inp",   96'(clf_inp),   96'(0));
    check("rst_frame_err", 96'(frame_err), 96'(0));
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_ready", 96'(s_ready), 96'(1));

    // Vector table.
    for (int i = 0; i < 6; i++)
      run_record(tbl[i].base, tbl[i].step, tbl[i].bp, tbl[i].cls, tbl[i].votes);

    // Reset mid-frame after 7 features.
    for (int k = 0; k < 7; k++) drive_feat(4'(k + 9), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_s_ready", 96'(s_ready), 96'(1));
    check("midrst_m_valid", 96'(m_valid), 96'(0));
    check("midrst_m_class", 96'(m_class), 96'(0));
    check("midrst_m_votes", 96'(m_votes), 96'(0));
    check("midrst_clf_inp", 96'(clf_inp), 96'(0));
    #2 rst_n = 1'b1;
    run_record(3, 5, 0, 2'd1, 6'h12);

    // Reset while a result is pending: m_valid drops without a clock edge.
    m_ready = 1'b0;
    for (int k = 0; k < NUM_FEAT; k++) drive_feat(feat(1, 1, k), k == NUM_FEAT - 1);
    @(posedge clk);
    #1;
    check("pend_m_valid", 96'(m_valid), 96'(1));
    #2 rst_n = 1'b0;
    #1;
    check("holdrst_m_valid", 96'(m_valid), 96'(0));
    check("holdrst_m_class", 96'(m_class), 96'(0));
    check("holdrst_m_votes", 96'(m_votes), 96'(0));
    check("holdrst_s_ready", 96'(s_ready), 96'(1));
    #1 rst_n = 1'b1;
    m_ready = 1'b1;

    // Early s_last on the 10th feature.
`ifdef CARDIO_SEQ_FRAME_CHECK_EN
    for (int k = 0; k < 10; k++) drive_feat(feat(2, 1, k), k == 9);
    check("early_frame_err", 96'(frame_err), 96'(1));
    @(posedge clk);
    #1;
    check("early_err_cleared", 96'(frame_err), 96'(0));
    check("early_no_m_valid", 96'(m_valid), 96'(0));
    check("early_s_ready", 96'(s_ready), 96'(1));
    run_record(2, 1, 0, 2'd1, 6'h03);
    // 21 features without s_last: discarded, no EVAL.
    for (int k = 0; k < NUM_FEAT; k++) drive_feat(feat(2, 1, k), 1'b0);
    check("nolast_frame_err", 96'(frame_err), 96'(1));
    check("nolast_s_ready", 96'(s_ready), 96'(1));
    @(posedge clk);
    #1;
    check("nolast_no_m_valid", 96'(m_valid), 96'(0));
    run_record(10, 3, 0, 2'd1, 6'h0B);
`else
    // s_last ignored: the record still ends on its 21st feature.
    for (int k = 0; k < NUM_FEAT; k++) begin
      drive_feat(feat(2, 1, k), k == 9);
      check("ign_frame_err", 96'(frame_err), 96'(0));
    end
    check("ign_eval_s_ready", 96'(s_ready), 96'(0));
    @(posedge clk);
    #1;
    check("ign_m_valid", 96'(m_valid), 96'(1));
    check("ign_m_class", 96'(m_class), 96'(1));
    check("ign_m_votes", 96'(m_votes), 96'(6'h03));
    @(posedge clk);
    #1;
    check("ign_release", 96'(s_ready), 96'(1));
`endif

    // Back-to-back records: m_ready and s_valid held high.
    m_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 76; c++) begin
      if (m_valid) hits.push_back(c);
      rdy     = s_ready;
      s_valid = 1'b1;
      s_data  = 4'(idx);
      s_last  = (idx == NUM_FEAT - 1);
      @(posedge clk);
      #1;
      if (rdy) idx = (idx == NUM_FEAT - 1) ? 0 : idx + 1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("b2b_pulse_count", 96'(hits.size()), 96'(3));
    if (hits.size() >= 3) begin
      check("b2b_first", 96'(hits[0]), 96'(22));
      check("b2b_period1", 96'(hits[1] - hits[0]), 96'(23));
      check("b2b_period2", 96'(hits[2] - hits[1]), 96'(23));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
